// File: rtl/mips_pkg.sv
// Shared MIPS core datapath constants: register file geometry and the zero register.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_array_2r1w.sv
// Register storage, 1 synchronous write / 2 combinational reads; reads see old contents until the edge.
// Always ready; synchronous active-low clear wipes every entry in one edge.
module reg_array_2r1w #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (WriteEn) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  assign ReadData1 = mem[ReadAddr1];
  assign ReadData2 = mem[ReadAddr2];

endmodule

// File: rtl/writeback_regfile.sv
// MIPS writeback stage + 32x32 register file with same-cycle WB->ID bypass; result and reads are combinational.
// No handshake: always accepts; upstream stalls/flushes are expressed by dropping RegWriteW.
module writeback_regfile
  import mips_pkg::REG_ZERO;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [31:0]       WriteCount
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic              commitEn;
  logic [DATA_W-1:0] arrayRd1;
  logic [DATA_W-1:0] arrayRd2;
  logic [31:0]       writeCountQ;

  assign ResultW  = MemtoRegW ? ReadDataW : ALUOutW;
  // Reset gates the enable so a write in the reset cycle neither commits nor bypasses.
  assign commitEn = Reset & RegWriteW & (WriteRegW != ZeroAddr);

  reg_array_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uArray (
    .CLK       (CLK),
    .Reset     (Reset),
    .WriteEn   (commitEn),
    .WriteAddr (WriteRegW),
    .WriteData (ResultW),
    .ReadAddr1 (A1),
    .ReadAddr2 (A2),
    .ReadData1 (arrayRd1),
    .ReadData2 (arrayRd2)
  );

  always_comb begin
    RD1 = arrayRd1;
    if (A1 == ZeroAddr) begin
      RD1 = '0;
    end else if (commitEn && (A1 == WriteRegW)) begin
      RD1 = ResultW;
    end
  end

  always_comb begin
    RD2 = arrayRd2;
    if (A2 == ZeroAddr) begin
      RD2 = '0;
    end else if (commitEn && (A2 == WriteRegW)) begin
      RD2 = ResultW;
    end
  end

  // Free-running wrap at 2^32 is intended; consumers take differences.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      writeCountQ <= '0;
    end else if (commitEn) begin
      writeCountQ <= writeCountQ + 32'd1;
    end
  end

  assign WriteCount = writeCountQ;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboarded bench for writeback_regfile: directed cases then a random soak
// against an array-based reference model.
module tb_writeback_regfile;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] ReadDataW = '0;
  logic [31:0] ALUOutW = '0;
  logic        RegWriteW = 1'b0;
  logic        MemtoRegW = 1'b0;
  logic [4:0]  WriteRegW = '0;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [31:0] ResultW;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WriteCount;

  writeback_regfile dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WriteRegW  (WriteRegW),
    .A1         (A1),
    .A2         (A2),
    .ResultW    (ResultW),
    .RD1        (RD1),
    .RD2        (RD2),
    .WriteCount (WriteCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic [31:0] cnt;
    bit          chkRd;
    bit          chkCnt;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] mregs [32];
  logic [31:0] mcount = '0;
  bit          arrayKnown = 1'b0;
  bit          countKnown = 1'b0;
  int          nCompared = 0;
  int          nMismatched = 0;

  task automatic check(input string name, input string field, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("FAIL %s.%s got=%08h want=%08h at %0t", name, field, got, want, $time);
    end
  endtask

  // Drives one cycle of stimulus, queues what the outputs must show before the
  // coming edge, then advances the model past that edge.
  task automatic drive(input logic rst, input logic we, input logic m2r, input logic [4:0] wr,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] rdat, input logic [31:0] alu, input string name);
    exp_t        e;
    logic [31:0] res;
    logic        commit;
    @(negedge CLK);
    Reset = rst; RegWriteW = we; MemtoRegW = m2r; WriteRegW = wr;
    A1 = a1; A2 = a2; ReadDataW = rdat; ALUOutW = alu;
    res    = m2r ? rdat : alu;
    commit = rst & we & (wr != 5'd0);
    e.name   = name;
    e.res    = res;
    e.rd1    = (a1 == 5'd0) ? 32'd0 : (commit && a1 == wr) ? res : mregs[a1];
    e.rd2    = (a2 == 5'd0) ? 32'd0 : (commit && a2 == wr) ? res : mregs[a2];
    e.cnt    = mcount;
    e.chkRd  = arrayKnown;
    e.chkCnt = countKnown;
    sbQ.push_back(e);
    if (!rst) begin
      foreach (mregs[i]) mregs[i] = '0;
      mcount     = '0;
      arrayKnown = 1'b1;
      countKnown = 1'b1;
    end else begin
      if (we !== 1'b0 && we !== 1'b1) countKnown = 1'b0;
      if (commit === 1'b1) begin
        mregs[wr] = res;
        mcount    = mcount + 32'd1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input string name);
    drive(1'b1, 1'b0, 1'b0, 5'd0, a1, a2, 32'd0, 32'd0, name);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check(e.name, "ResultW", ResultW, e.res);
        if (e.chkRd) begin
          check(e.name, "RD1", RD1, e.rd1);
          check(e.name, "RD2", RD2, e.rd2);
        end
        if (e.chkCnt) check(e.name, "WriteCount", WriteCount, e.cnt);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] held;
    logic [4:0]  wr, a1, a2;
    foreach (mregs[i]) mregs[i] = '0;

    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "por_reset");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd17, 32'd0, 32'd0, "por_reset2");
    idle(5'd5, 5'd17, "reset_state");
    idle(5'd31, 5'd1, "reset_state2");

    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd7, 32'd0, 32'hDEADBEEF, "preload_r5");
    drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd5, 5'd7, 32'd0, 32'h0000_7777, "reset_with_write");
    idle(5'd5, 5'd7, "after_reset_r5");
    idle(5'd7, 5'd5, "after_reset_r7");

    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'h22, 32'h11, "sel_alu");
    idle(5'd3, 5'd0, "sel_alu_rd");
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 32'h22, 32'h11, "sel_mem");
    idle(5'd3, 5'd3, "sel_mem_rd");

    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 32'h55, 32'hAB, "bypass_both");
    idle(5'd9, 5'd3, "bypass_array");

    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'hFFFF_FFFF, "r0_write");
    idle(5'd0, 5'd9, "r0_next");

    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 32'd0, 32'h1234, "preload_r4");
    drive(1'b1, 1'b0, 1'b0, 5'd4, 5'd1, 5'd4, 32'h9999, 32'h8888, "disabled_wr");
    idle(5'd9, 5'd4, "disabled_after");

    // Unknown write enable: only r12 may be touched, and it is offered its own value.
    for (int i = 1; i < 32; i++)
      drive(1'b1, 1'b1, 1'b0, 5'(i), 5'd0, 5'd0, 32'd0, 32'h100 + 32'(i) * 32'h01010101, "fill");
    held = mregs[12];
    drive(1'b1, 1'bx, 1'b0, 5'd12, 5'd13, 5'd12, 32'hCAFE, held, "x_we");
    for (int i = 0; i < 16; i++)
      idle(5'(2 * i), 5'(2 * i + 1), "x_sweep");

    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0, "resync_reset");
    idle(5'd12, 5'd30, "resync_state");
    @(posedge CLK);
    #3;
    force dut.writeCountQ = 32'hFFFF_FFFF;
    #1;
    release dut.writeCountQ;
    mcount = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, 1'b1, 5'd20, 5'd20, 5'd0, 32'h4242, 32'd0, "wrap_commit");
    idle(5'd20, 5'd0, "wrap_after");

    for (int n = 0; n < 10000; n++) begin
      wr = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            wr, a1, a2, $urandom, $urandom, "soak");
    end

    for (int w = 0; w < 10 && sbQ.size() > 0; w++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    #4;
    if (sbQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain pending=%0d want=0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
